alu_core: RTL and testbench

- Registered 32-bit datapath ALU for the lab CPU; one-hot operation selects from the control unit, 64-bit result C for the Z/HI-LO registers.
- Integer core: 4-bit-group carry-lookahead adder/subtractor, sequential radix-2 Booth signed multiplier, sequential signed divider, logic/shift/rotate, PC increment.
- Logic, add/sub, shift/rotate, NEG, NOT and IncPC complete in 1 cycle; MUL and DIV take 32 cycles.

---
 rtl/alu_core.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered ALU: single-cycle logic/arith/shift ops, 32-cycle Booth multiply and signed divide.
// Optional ALU_DIV_ERR_EN adds a div_err output flagging divide-by-zero.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               AND,
  input  logic               OR,
  input  logic               ADD,
  input  logic               SUB,
  input  logic               MUL,
  input  logic               DIV,
  input  logic               SHR,
  input  logic               SHL,
  input  logic               ROR,
  input  logic               ROL,
  input  logic               NEG,
  input  logic               NOT,
  input  logic               IncPC,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done
`ifdef ALU_DIV_ERR_EN
  ,
  output logic               div_err
`endif
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_NONE, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
    OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_INC
  } op_t;

  op_t op;

  always_comb begin
    op = OP_NONE;
    if      (AND)   op = OP_AND;
    else if (OR)    op = OP_OR;
    else if (ADD)   op = OP_ADD;
    else if (SUB)   op = OP_SUB;
    else if (MUL)   op = OP_MUL;
    else if (DIV)   op = OP_DIV;
    else if (SHR)   op = OP_SHR;
    else if (SHL)   op = OP_SHL;
    else if (ROR)   op = OP_ROR;
    else if (ROL)   op = OP_ROL;
    else if (NEG)   op = OP_NEG;
    else if (NOT)   op = OP_NOT;
    else if (IncPC) op = OP_INC;
  end

  // 4-bit lookahead group: returns {group generate, group propagate, sum}
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g, p, c;
    logic gg, pg;
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg = &p;
    return {gg, pg, p ^ c};
  endfunction

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH/4:0]   gc;
  logic [5:0]         grp;

  always_comb begin
    add_b  = (op == OP_SUB) ? ~B : B;
    gc     = '0;
    gc[0]  = (op == OP_SUB);
    sum    = '0;
    grp    = '0;
    for (int unsigned i = 0; i < WIDTH/4; i++) begin
      grp = cla4(A[4*i +: 4], add_b[4*i +: 4], gc[i]);
      sum[4*i +: 4] = grp[3:0];
      gc[i+1] = grp[5] | (grp[4] & gc[i]);
    end
  end

  logic               sh_big;
  logic [SW-1:0]      amt;
  logic [2*WIDTH-1:0] ror_w, rol_w;
  logic [2*WIDTH-1:0] res;

  always_comb begin
    sh_big = |B[WIDTH-1:SW];
    amt    = B[SW-1:0];
    ror_w  = {A, A} >> amt;
    rol_w  = {A, A} << amt;
    res    = '0;
    case (op)
      OP_AND: res[WIDTH-1:0] = A & B;
      OP_OR:  res[WIDTH-1:0] = A | B;
      OP_ADD,
      OP_SUB: res = {{WIDTH{sum[WIDTH-1]}}, sum};
      OP_SHR: res[WIDTH-1:0] = sh_big ? '0 : (A >> amt);
      OP_SHL: res[WIDTH-1:0] = sh_big ? '0 : (A << amt);
      OP_ROR: res[WIDTH-1:0] = ror_w[WIDTH-1:0];
      OP_ROL: res[WIDTH-1:0] = rol_w[2*WIDTH-1:WIDTH];
      OP_NEG: res[WIDTH-1:0] = ~B + WIDTH'(1);
      OP_NOT: res[WIDTH-1:0] = ~B;
      OP_INC: res[WIDTH-1:0] = B + WIDTH'(4);
      default: res = '0;
    endcase
  end

  // Booth register {hi (sign-extended one bit), lo = multiplier, q-1}
  logic [2*WIDTH+1:0] prod, prod_nx;
  logic [WIDTH:0]     mcand, hi_sum;

  always_comb begin
    case (prod[1:0])
      2'b01:   hi_sum = prod[2*WIDTH+1:WIDTH+1] + mcand;
      2'b10:   hi_sum = prod[2*WIDTH+1:WIDTH+1] - mcand;
      default: hi_sum = prod[2*WIDTH+1:WIDTH+1];
    endcase
    prod_nx = {hi_sum[WIDTH], hi_sum, prod[WIDTH:1]};
  end

  // Restoring division on magnitudes; signs are applied on the final step
  logic [WIDTH-1:0] rem, quo, dvs, a_cap;
  logic             neg_q, neg_r, is_div;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;
  logic [2*WIDTH-1:0] div_res;
  logic             dvs_zero;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    ge       = shifted >= {1'b0, dvs};
    rem_nx   = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    quo_nx   = {quo[WIDTH-2:0], ge};
    q_fin    = neg_q ? (~quo_nx + WIDTH'(1)) : quo_nx;
    r_fin    = neg_r ? (~rem_nx + WIDTH'(1)) : rem_nx;
    dvs_zero = (dvs == '0);
    div_res  = dvs_zero ? {a_cap, {WIDTH{1'b1}}} : {r_fin, q_fin};
  end

  logic [SW-1:0] cnt;
  logic          wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      C      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr     <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      a_cap  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef ALU_DIV_ERR_EN
      div_err <= 1'b0;
`endif
    end else begin
      wr   <= 1'b0;
      done <= wr;
      if (busy) begin
        cnt  <= cnt + 1'b1;
        prod <= prod_nx;
        rem  <= rem_nx;
        quo  <= quo_nx;
        if (&cnt) begin
          C    <= is_div ? div_res : prod_nx[2*WIDTH:1];
          busy <= 1'b0;
          wr   <= 1'b1;
`ifdef ALU_DIV_ERR_EN
          div_err <= is_div & dvs_zero;
`endif
        end
      end else begin
        case (op)
          OP_NONE: ;
          OP_MUL: begin
            busy   <= 1'b1;
            is_div <= 1'b0;
            cnt    <= '0;
            mcand  <= {A[WIDTH-1], A};
            prod   <= {{(WIDTH+1){1'b0}}, B, 1'b0};
          end
          OP_DIV: begin
            busy   <= 1'b1;
            is_div <= 1'b1;
            cnt    <= '0;
            a_cap  <= A;
            rem    <= '0;
            quo    <= A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
            dvs    <= B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
            neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r  <= A[WIDTH-1];
          end
          default: begin
            C  <= res;
            wr <= 1'b1;
`ifdef ALU_DIV_ERR_EN
            div_err <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; expected values computed by hand.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic [31:0] A, B;
  logic [63:0] C;
  logic        busy, done;
`ifdef ALU_DIV_ERR_EN
  logic        div_err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  localparam logic [12:0] S_AND = 13'h1000, S_OR  = 13'h0800, S_ADD = 13'h0400,
                          S_SUB = 13'h0200, S_MUL = 13'h0100, S_DIV = 13'h0080,
                          S_SHR = 13'h0040, S_SHL = 13'h0020, S_ROR = 13'h0010,
                          S_ROL = 13'h0008, S_NEG = 13'h0004, S_NOT = 13'h0002,
                          S_INC = 13'h0001;

  alu_core #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
    .A(A), .B(B), .C(C), .busy(busy), .done(done)
`ifdef ALU_DIV_ERR_EN
    , .div_err(div_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sel(input logic [12:0] s);
    {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC} = s;
  endtask

  task automatic run_single(input string tag, input logic [12:0] s,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
    @(negedge clk);
    A = a; B = b; set_sel(s);
    @(posedge clk); #1;
    set_sel('0);
    check(tag, C, exp);
    check({tag, "_done0"}, {63'b0, done}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {63'b0, done}, 64'd1);
  endtask

  task automatic run_multi(input string tag, input logic [12:0] s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
    int cyc;
    @(negedge clk);
    A = a; B = b; set_sel(s);
    @(posedge clk); #1;
    set_sel('0);
    A = 32'h5A5A5A5A; B = 32'hA5A5A5A5;
    check({tag, "_busy"}, {63'b0, busy}, 64'd1);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_cycles"}, 64'(cyc), 64'd32);
    check(tag, C, exp);
    @(posedge clk); #1;
    check({tag, "_done"}, {63'b0, done}, 64'd1);
  endtask

  initial begin
    int cyc;
    logic saw;
    reset_n = 1'b0;
    set_sel('0);
    A = '0; B = '0;
    #12;
    check("rst_C", C, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    run_single("and", S_AND, 32'hF0F01234, 32'h0FF0FF00, 64'h00000000_00F01200);
    run_single("or",  S_OR,  32'hF0F01234, 32'h0FF0FF00, 64'h00000000_FFF0FF34);
    run_single("add_neg", S_ADD, 32'd5, 32'hFFFFFFF6, 64'hFFFFFFFF_FFFFFFFB);
    run_single("sub", S_SUB, 32'd10, 32'd3, 64'h00000000_00000007);
    run_single("sub_neg", S_SUB, 32'd3, 32'd10, 64'hFFFFFFFF_FFFFFFF9);
    run_single("add_ovf", S_ADD, 32'h7FFFFFFF, 32'd1, 64'hFFFFFFFF_80000000);
    run_single("ror1", S_ROR, 32'h80000001, 32'd1, 64'h00000000_C0000000);
    run_single("rol4", S_ROL, 32'h80000001, 32'd4, 64'h00000000_00000018);
    run_single("ror0", S_ROR, 32'h80000001, 32'd0, 64'h00000000_80000001);
    run_single("shr32", S_SHR, 32'h80000001, 32'd32, 64'd0);
    run_single("shl31", S_SHL, 32'h80000001, 32'd31, 64'h00000000_80000000);
    run_single("shr1", S_SHR, 32'h80000001, 32'd1, 64'h00000000_40000000);
    run_single("neg", S_NEG, 32'd0, 32'd5, 64'h00000000_FFFFFFFB);
    run_single("not", S_NOT, 32'd0, 32'd0, 64'h00000000_FFFFFFFF);
    run_single("inc", S_INC, 32'd0, 32'h00000100, 64'h00000000_00000104);
    run_single("inc_wrap", S_INC, 32'd0, 32'hFFFFFFFC, 64'd0);
    run_single("pri_addsub", S_ADD | S_SUB, 32'd10, 32'd3, 64'h00000000_0000000D);
    run_single("pri_andinc", S_AND | S_INC, 32'h0000FFFF, 32'h00FF00FF, 64'h00000000_000000FF);

    // no select: C holds, done stays low
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_C", C, 64'h00000000_000000FF);
    check("hold_done", {63'b0, done}, 64'd0);

    run_multi("mul_neg", S_MUL, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    run_multi("mul_min", S_MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_multi("div_neg", S_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
`ifdef ALU_DIV_ERR_EN
    check("div_err0", {63'b0, div_err}, 64'd0);
`endif
    run_multi("div_mix", S_DIV, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2);
    run_multi("div_zero", S_DIV, 32'h00000012, 32'd0, 64'h00000012_FFFFFFFF);
`ifdef ALU_DIV_ERR_EN
    check("div_err1", {63'b0, div_err}, 64'd1);
`endif
    run_multi("div_ovf", S_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    // busy lockout: AND raised mid-multiply is ignored
    @(negedge clk);
    A = 32'd6; B = 32'hFFFFFFFB; set_sel(S_MUL);
    @(posedge clk); #1;
    set_sel('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; set_sel(S_AND);
    repeat (2) @(posedge clk);
    #1;
    check("lock_hold", C, 64'h00000000_80000000);
    set_sel('0);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lock_result", C, 64'hFFFFFFFF_FFFFFFE2);

    // reset during multiply aborts it
    @(negedge clk);
    A = 32'd7; B = 32'd9; set_sel(S_MUL);
    @(posedge clk); #1;
    set_sel('0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_C", C, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy || C != 64'd0) saw = 1'b1;
    end
    check("abort_quiet", {63'b0, saw}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
